answer_judge: RTL and testbench
===============================

# answer_judge

N-player answer arbiter for the factorization quiz game: decides which player(s) submitted a correct answer first within a round, with draw detection, optional wrong-answer lockout and a round timeout. It generalises the two-player win/lose decision to `N_PLAYERS` channels and adds a round state machine with held results. It sits between the per-player answer checkers (upstream) and HP management (downstream).

## Interface
- `N_PLAYERS`, 2, number of answer channels (2..16); channel 0 is the local player.
- `TIMEOUT_CYC`, 1000, round length in CLK cycles; 0 disables the timeout.
- `LOCKOUT`, 1, 1: a wrong answer locks that player out for the rest of the round; 0: retries allowed.
- `CLK` input 1: system clock; all state is updated on the rising edge.
- `RST` input 1: asynchronous, active-low reset.
- `ROUND_START` input 1: single-cycle pulse that opens a new round.
- `ANS_VALID` input N_PLAYERS: per-player answer strobe, one cycle per submission.
- `ANS_OK` input N_PLAYERS: per-player correctness, qualified by `ANS_VALID`.
- `RESULT_VALID` output 1: high while a round result is held (state DONE).
- `RESULT` output 2: 00 no result / round open, 01 single winner, 11 draw, 10 no winner.
- `WIN_MASK` output N_PLAYERS: players correct in the deciding cycle.
- `WIN_ID` output max(1,$clog2(N_PLAYERS)): lowest-index set bit of `WIN_MASK`.
- `TIMED_OUT` output 1: with `RESULT`=10, set when the round ended by timeout; clear when it ended because every player was locked out.
- `LOCK_MASK` output N_PLAYERS: players currently locked out.
- `BUSY` output 1: high in state OPEN.

## Operation
- FSM states: IDLE, OPEN, DONE. Reset enters IDLE. All outputs reset to 0.
- IDLE or DONE, `ROUND_START`=1 -> OPEN. Clears `WIN_MASK`, `WIN_ID`, `RESULT`, `TIMED_OUT` and `LOCK_MASK`, and loads the timer with `TIMEOUT_CYC`.
- OPEN, `ROUND_START`=1 -> the round restarts (same clear/reload as above). Answers presented in that cycle are ignored.
- OPEN, an answer is eligible when `ANS_VALID[i]`=1 and `LOCK_MASK[i]`=0.
- OPEN, correct set C = eligible & `ANS_OK`. If C is non-empty, go to DONE with `WIN_MASK`=C and `RESULT`=01 (popcount 1) or 11 (popcount >1).
- OPEN, if `LOCKOUT`=1, wrong set W = eligible & ~`ANS_OK` is ORed into `LOCK_MASK`. If `LOCK_MASK` then becomes all ones and C is empty, go to DONE with `RESULT`=10 and `TIMED_OUT`=0.
- OPEN, if `TIMEOUT_CYC`>0, the timer decrements every OPEN cycle. When it expires with C empty, go to DONE with `RESULT`=10 and `TIMED_OUT`=1.
- Priority within one cycle: `ROUND_START` > correct answer > all-locked > timeout.
- DONE holds every output stable until `ROUND_START` arrives. Answers received in DONE are ignored.
- `LOCKOUT`=0: `LOCK_MASK` stays 0, and the round ends only on a correct answer or timeout.
- `TIMEOUT_CYC`=0 with `LOCKOUT`=0: the round stays open until a correct answer or a restart.
- Timer width is $clog2(TIMEOUT_CYC+1) and the counter saturates at 0, so it never wraps.

## Timing
- `ROUND_START` at edge k -> `BUSY`=1 from k+1. The first answer that can be accepted is sampled at edge k+1.
- An answer sampled at edge k -> `RESULT`, `WIN_MASK`, `WIN_ID` and `RESULT_VALID` update after edge k, so they are valid in cycle k+1 (latency 1). `BUSY` falls in the same cycle.
- Timeout: with `ROUND_START` at edge k, the last cycle in which an answer is accepted is sampled at edge k+`TIMEOUT_CYC`. `RESULT`=10 is shown after that edge if no correct answer arrived.
- A correct answer sampled on the expiry edge wins, not the timeout.
- `RST` low at any time, including mid-round, forces IDLE and zeroes all outputs asynchronously. There is no result output on the first edge after reset is released.

## Structure
- Package `judge_pkg`: `RESULT` codes (RES_NONE=00, RES_WIN=01, RES_NOWIN=10, RES_DRAW=11) and the state typedef (IDLE/OPEN/DONE). Shared with HP management.
- Sub-module `round_timer`:
  - parameter `TIMEOUT_CYC`;
  - inputs `load` and `en`;
  - output `expired`;
  - asynchronous active-low reset.
- The lowest-index priority encoder for `WIN_ID` and the popcount>1 draw detect are combinational in `answer_judge`.

## Test plan
- N=2, correct answer on player 1 at cycle 5 after start -> one cycle later `RESULT`=01, `WIN_MASK`=2'b10, `WIN_ID`=1, `RESULT_VALID`=1, held until the next `ROUND_START`.
- N=4, players 0 and 2 correct in the same cycle -> `RESULT`=11, `WIN_MASK`=4'b0101, `WIN_ID`=0.
- N=3, `LOCKOUT`=1: player 1 wrong, then player 1 correct, then players 0 and 2 wrong -> player 1's correct answer is ignored, `LOCK_MASK`=3'b111, `RESULT`=10, `TIMED_OUT`=0.
- `TIMEOUT_CYC`=8, no answers -> `RESULT`=10 and `TIMED_OUT`=1 after the 8th OPEN edge. A second run with a correct answer exactly on the expiry edge -> `RESULT`=01.
- `ROUND_START` mid-round with a correct answer in the same cycle -> round restarts, `RESULT`=00, `BUSY`=1, and the answer is ignored.
- `RST` asserted low in OPEN and in DONE -> all outputs 0 immediately. After release, the block stays in IDLE until `ROUND_START`.

Source files
------------

// File: rtl/judge_pkg.sv
// Shared result codes and round-state type for the answer arbiter and HP management.
package judge_pkg;

    localparam int unsigned RES_W = 2;

    typedef logic [RES_W-1:0] result_t;

    localparam result_t RES_NONE  = 2'b00;
    localparam result_t RES_WIN   = 2'b01;
    localparam result_t RES_NOWIN = 2'b10;
    localparam result_t RES_DRAW  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OPEN = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/round_timer.sv
// Round countdown: loads TIMEOUT_CYC on start, counts down while the round is open, saturates at 0.
module round_timer #(
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(TIMEOUT_CYC);
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The edge on which the count leaves 1 is the last edge an answer is accepted.
    assign expired = (TIMEOUT_CYC != 0) && en && !load && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/answer_judge.sv
// N-player answer arbiter: first correct answer(s) win, with draw, lockout and round timeout.
module answer_judge
    import judge_pkg::*;
#(
    parameter int unsigned N_PLAYERS   = 2,
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter int unsigned LOCKOUT     = 1,
    localparam int unsigned ID_W       = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 round_start_i,
    input  logic [N_PLAYERS-1:0] ans_valid_i,
    input  logic [N_PLAYERS-1:0] ans_ok_i,
    output logic                 result_valid_o,
    output logic [RES_W-1:0]     result_o,
    output logic [N_PLAYERS-1:0] win_mask_o,
    output logic [ID_W-1:0]      win_id_o,
    output logic                 timed_out_o,
    output logic [N_PLAYERS-1:0] lock_mask_o,
    output logic                 busy_o
);

    state_e                 state_q, state_d;
    result_t                result_q, result_d;
    logic [N_PLAYERS-1:0]   win_mask_q, win_mask_d;
    logic [ID_W-1:0]        win_id_q, win_id_d;
    logic                   timed_out_q, timed_out_d;
    logic [N_PLAYERS-1:0]   lock_mask_q, lock_mask_d;
    logic                   busy_q, busy_d;
    logic                   rvalid_q, rvalid_d;

    logic [N_PLAYERS-1:0]   eligible_c, correct_c, wrong_c, lock_upd_c;
    logic                   all_locked_c, multi_c, timer_en_c, expired_c;
    logic [ID_W-1:0]        win_id_c;

    assign eligible_c   = ans_valid_i & ~lock_mask_q;
    assign correct_c    = eligible_c & ans_ok_i;
    assign wrong_c      = eligible_c & ~ans_ok_i;
    assign lock_upd_c   = (LOCKOUT != 0) ? (lock_mask_q | wrong_c) : '0;
    assign all_locked_c = (LOCKOUT != 0) && (&lock_upd_c);
    // Clearing the lowest set bit leaves something only if two or more players were correct.
    assign multi_c      = (correct_c & (correct_c - N_PLAYERS'(1))) != '0;
    assign timer_en_c   = (state_q == OPEN) && !round_start_i;

    // Lowest-index priority encoder over the correct set.
    always_comb begin
        win_id_c = '0;
        for (int i = int'(N_PLAYERS) - 1; i >= 0; i--) begin
            if (correct_c[i]) begin
                win_id_c = ID_W'(i);
            end
        end
    end

    round_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (round_start_i),
        .en      (timer_en_c),
        .expired (expired_c)
    );

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        win_mask_d  = win_mask_q;
        win_id_d    = win_id_q;
        timed_out_d = timed_out_q;
        lock_mask_d = lock_mask_q;

        case (state_q)
            IDLE, DONE: begin
                if (round_start_i) begin
                    state_d     = OPEN;
                    result_d    = RES_NONE;
                    win_mask_d  = '0;
                    win_id_d    = '0;
                    timed_out_d = 1'b0;
                    lock_mask_d = '0;
                end
            end
            OPEN: begin
                if (round_start_i) begin
                    result_d    = RES_NONE;
                    win_mask_d  = '0;
                    win_id_d    = '0;
                    timed_out_d = 1'b0;
                    lock_mask_d = '0;
                end else begin
                    lock_mask_d = lock_upd_c;
                    if (correct_c != '0) begin
                        state_d    = DONE;
                        win_mask_d = correct_c;
                        win_id_d   = win_id_c;
                        result_d   = multi_c ? RES_DRAW : RES_WIN;
                    end else if (all_locked_c) begin
                        state_d     = DONE;
                        result_d    = RES_NOWIN;
                        timed_out_d = 1'b0;
                    end else if (expired_c) begin
                        state_d     = DONE;
                        result_d    = RES_NOWIN;
                        timed_out_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d   = (state_d == OPEN);
        rvalid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            result_q    <= RES_NONE;
            win_mask_q  <= '0;
            win_id_q    <= '0;
            timed_out_q <= 1'b0;
            lock_mask_q <= '0;
            busy_q      <= 1'b0;
            rvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            win_mask_q  <= win_mask_d;
            win_id_q    <= win_id_d;
            timed_out_q <= timed_out_d;
            lock_mask_q <= lock_mask_d;
            busy_q      <= busy_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign result_valid_o = rvalid_q;
    assign result_o       = result_q;
    assign win_mask_o     = win_mask_q;
    assign win_id_o       = win_id_q;
    assign timed_out_o    = timed_out_q;
    assign lock_mask_o    = lock_mask_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_answer_judge.sv
// Scoreboard bench for answer_judge: 4 players, 8-cycle timeout, lockout enabled.
module tb_answer_judge;

    localparam int unsigned N = 4;
    localparam int unsigned T = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         round_start_i = 1'b0;
    logic [N-1:0] ans_valid_i = '0;
    logic [N-1:0] ans_ok_i = '0;
    logic         result_valid_o;
    logic [1:0]   result_o;
    logic [N-1:0] win_mask_o;
    logic [1:0]   win_id_o;
    logic         timed_out_o;
    logic [N-1:0] lock_mask_o;
    logic         busy_o;

    answer_judge #(
        .N_PLAYERS   (N),
        .TIMEOUT_CYC (T),
        .LOCKOUT     (1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .round_start_i  (round_start_i),
        .ans_valid_i    (ans_valid_i),
        .ans_ok_i       (ans_ok_i),
        .result_valid_o (result_valid_o),
        .result_o       (result_o),
        .win_mask_o     (win_mask_o),
        .win_id_o       (win_id_o),
        .timed_out_o    (timed_out_o),
        .lock_mask_o    (lock_mask_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]   res;
        logic [N-1:0] mask;
        logic [1:0]   id;
        logic         to;
        logic [N-1:0] lock;
        int           at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic rv_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: each rising result_valid pops one expected result.
    always @(negedge clk) begin
        if (result_valid_o && !rv_prev) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got result %0h mask %0h with nothing expected (cycle %0d)",
                         result_o, win_mask_o, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_result", 32'(result_o), 32'(mon_e.res));
                chk("sb_win_mask", 32'(win_mask_o), 32'(mon_e.mask));
                chk("sb_win_id", 32'(win_id_o), 32'(mon_e.id));
                chk("sb_timed_out", 32'(timed_out_o), 32'(mon_e.to));
                chk("sb_lock_mask", 32'(lock_mask_o), 32'(mon_e.lock));
                chk("sb_latency_cycle", 32'(cyc), 32'(mon_e.at));
                chk("sb_busy_low", 32'(busy_o), 32'd0);
            end
        end
        rv_prev = result_valid_o;
    end

    task automatic drive(input logic rs, input logic [N-1:0] v, input logic [N-1:0] ok);
        @(negedge clk);
        round_start_i = rs;
        ans_valid_i   = v;
        ans_ok_i      = ok;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, '0);
    endtask

    task automatic start_round(output int c);
        drive(1'b1, '0, '0);
        c = cyc;
    endtask

    task automatic expect_res(input logic [1:0] res, input logic [N-1:0] mask, input logic [1:0] id,
                              input logic to, input logic [N-1:0] lock, input int at);
        exp_t e;
        e.res = res; e.mask = mask; e.id = id; e.to = to; e.lock = lock; e.at = at;
        sb.push_back(e);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_result_valid"}, 32'(result_valid_o), 32'd0);
        chk({tag, "_result"}, 32'(result_o), 32'd0);
        chk({tag, "_win_mask"}, 32'(win_mask_o), 32'd0);
        chk({tag, "_win_id"}, 32'(win_id_o), 32'd0);
        chk({tag, "_timed_out"}, 32'(timed_out_o), 32'd0);
        chk({tag, "_lock_mask"}, 32'(lock_mask_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int c;
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        chk("idle_after_reset_busy", 32'(busy_o), 32'd0);

        // Single winner: player 1 correct on the 5th edge after start, then held.
        start_round(c);
        idle(1);
        chk("busy_after_start", 32'(busy_o), 32'd1);
        idle(3);
        drive(1'b0, 4'b0010, 4'b0010);
        expect_res(2'b01, 4'b0010, 2'd1, 1'b0, 4'b0000, cyc + 1);
        drive(1'b0, 4'b0001, 4'b0001);
        idle(2);
        chk("held_result", 32'(result_o), 32'h1);
        chk("held_win_mask", 32'(win_mask_o), 32'h2);
        chk("held_win_id", 32'(win_id_o), 32'h1);
        chk("held_valid", 32'(result_valid_o), 32'd1);
        chk("held_busy", 32'(busy_o), 32'd0);

        // Draw: players 0 and 2 correct together.
        start_round(c);
        drive(1'b0, 4'b0101, 4'b0101);
        expect_res(2'b11, 4'b0101, 2'd0, 1'b0, 4'b0000, cyc + 1);
        idle(3);

        // Lockout: player 1 wrong, then correct (ignored), then the rest wrong.
        start_round(c);
        drive(1'b0, 4'b0010, 4'b0000);
        drive(1'b0, 4'b0010, 4'b0010);
        drive(1'b0, 4'b1101, 4'b0000);
        expect_res(2'b10, 4'b0000, 2'd0, 1'b0, 4'b1111, cyc + 1);
        idle(3);

        // Timeout with no answers: result after the 8th open edge.
        start_round(c);
        expect_res(2'b10, 4'b0000, 2'd0, 1'b1, 4'b0000, c + 1 + int'(T));
        idle(int'(T) + 3);

        // Correct answer on the expiry edge beats the timeout.
        start_round(c);
        idle(int'(T) - 1);
        drive(1'b0, 4'b0100, 4'b0100);
        expect_res(2'b01, 4'b0100, 2'd2, 1'b0, 4'b0000, c + 1 + int'(T));
        idle(3);

        // Restart mid-round with a correct answer in the same cycle: answer ignored, timer reloaded.
        start_round(c);
        drive(1'b0, 4'b0001, 4'b0000);
        idle(1);
        drive(1'b1, 4'b0001, 4'b0001);
        c = cyc;
        expect_res(2'b10, 4'b0000, 2'd0, 1'b1, 4'b0000, c + 1 + int'(T));
        idle(1);
        chk("restart_result", 32'(result_o), 32'd0);
        chk("restart_busy", 32'(busy_o), 32'd1);
        chk("restart_valid", 32'(result_valid_o), 32'd0);
        chk("restart_lock_cleared", 32'(lock_mask_o), 32'd0);
        idle(int'(T) + 3);

        // Reset in OPEN.
        start_round(c);
        drive(1'b0, 4'b0010, 4'b0000);
        idle(1);
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_open");
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        chk("post_rst_open_busy", 32'(busy_o), 32'd0);
        drive(1'b0, 4'b1000, 4'b1000);
        idle(2);
        chk("post_rst_open_valid", 32'(result_valid_o), 32'd0);

        // Reset in DONE.
        start_round(c);
        drive(1'b0, 4'b1000, 4'b1000);
        expect_res(2'b01, 4'b1000, 2'd3, 1'b0, 4'b0000, cyc + 1);
        idle(2);
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_done");
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        chk("post_rst_done_busy", 32'(busy_o), 32'd0);
        chk("post_rst_done_valid", 32'(result_valid_o), 32'd0);

        idle(4);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
